// File: rtl/dbg_cmd_pkg.sv
`default_nettype none
// ============================================================================
// dbg_cmd_pkg : default sizes, queued command type and IR one-hot decode
// Revision    : 1.0
// ============================================================================
package dbg_cmd_pkg;

   localparam int DATA_W      = 38;
   localparam int IR_W        = 2;
   localparam int DEPTH       = 4;
   localparam int SYNC_STAGES = 2;
   localparam int MAX_CMD     = 64;

   typedef struct packed {
      logic [IR_W-1:0]   ir;
      logic [DATA_W-1:0] data;
   } dbg_cmd_t;

   // Callers truncate the result to their own channel count.
   function automatic logic [MAX_CMD-1:0] action_onehot(input int unsigned ir);
      return MAX_CMD'(1) << ir;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_cmd_fifo.sv
`default_nettype none
// ============================================================================
// dbg_cmd_fifo : DEPTH-entry show-ahead command FIFO with occupancy output
// Revision     : 1.0
// ============================================================================
module dbg_cmd_fifo #(
   parameter int  DEPTH = dbg_cmd_pkg::DEPTH,
   parameter type T     = dbg_cmd_pkg::dbg_cmd_t
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  T                         push_data,
   input  logic                     pop,
   output T                         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] c_full_level = DEPTH[AW:0];

   T             r_mem [DEPTH];
   logic [AW:0]  r_wptr;
   logic [AW:0]  r_rptr;
   logic         w_wr_en;
   logic         w_rd_en;

   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign w_rd_en = pop && !empty;
   assign w_wr_en = push && (!full || w_rd_en);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_wr_en) r_wptr <= r_wptr + 1'b1;
         if (w_rd_en) r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wptr[AW-1:0]] <= push_data;
   end

   assign level = r_wptr - r_rptr;
   assign full  = (level == c_full_level);
   assign empty = (level == '0);
   assign head  = r_mem[r_rptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/dbg_cmd_sysclk_decoder.sv
`default_nettype none
// ============================================================================
// dbg_cmd_sysclk_decoder : syncs TCK update strobes, queues and decodes commands
// Optional feature macro : DBG_CMD_PARITY_EN (sr_par input, parity_err output)
// Revision               : 1.0
// ============================================================================
module dbg_cmd_sysclk_decoder #(
   parameter int DATA_W      = dbg_cmd_pkg::DATA_W,
   parameter int IR_W        = dbg_cmd_pkg::IR_W,
   parameter int ACTION_BIT  = DATA_W - 1,
   parameter int DEPTH       = dbg_cmd_pkg::DEPTH,
   parameter int SYNC_STAGES = dbg_cmd_pkg::SYNC_STAGES,
   localparam int N_CMD      = 2**IR_W
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [IR_W-1:0]          ir_in,
   input  logic [DATA_W-1:0]        sr,
   input  logic                     vs_udr,
   input  logic                     vs_uir,
   output logic                     cmd_valid,
   input  logic                     cmd_ready,
   output logic [IR_W-1:0]          cmd_ir,
   output logic [DATA_W-1:0]        jdo,
   output logic [N_CMD-1:0]         take_action,
   output logic [N_CMD-1:0]         take_no_action,
   output logic                     overflow,
`ifdef DBG_CMD_PARITY_EN
   input  logic                     sr_par,
   output logic                     parity_err,
`endif
   output logic [$clog2(DEPTH):0]   fifo_level
);

   import dbg_cmd_pkg::action_onehot;

   typedef struct packed {
      logic [IR_W-1:0]   ir;
      logic [DATA_W-1:0] data;
   } cmd_t;

   localparam int ARM_W = $clog2(SYNC_STAGES + 2);
   localparam logic [ARM_W-1:0] c_arm_done = ARM_W'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] r_udr_sync;
   logic [SYNC_STAGES-1:0] r_uir_sync;
   logic                   r_udr_edge;
   logic                   r_uir_edge;
   logic [ARM_W-1:0]       r_arm_cnt;
   logic                   w_armed;
   logic                   w_udr_rise;
   logic                   w_uir_rise;
   logic                   w_par_ok;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_full;
   logic                   w_empty;
   cmd_t                   w_push_data;
   cmd_t                   w_head;
   logic [N_CMD-1:0]       w_onehot;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_udr_sync <= '0;
         r_uir_sync <= '0;
         r_udr_edge <= 1'b0;
         r_uir_edge <= 1'b0;
         r_arm_cnt  <= '0;
      end else begin
         r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
         r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
         r_udr_edge <= r_udr_sync[SYNC_STAGES-1];
         r_uir_edge <= r_uir_sync[SYNC_STAGES-1];
         if (!w_armed) r_arm_cnt <= r_arm_cnt + 1'b1;
      end
   end

   // Masking until the chain has flushed keeps a strobe left high across reset silent.
   assign w_armed    = (r_arm_cnt == c_arm_done);
   assign w_udr_rise = w_armed && r_udr_sync[SYNC_STAGES-1] && !r_udr_edge;
   assign w_uir_rise = w_armed && r_uir_sync[SYNC_STAGES-1] && !r_uir_edge;

`ifdef DBG_CMD_PARITY_EN
   assign w_par_ok = ((^sr) == sr_par);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         parity_err <= 1'b0;
      end else begin
         if (w_uir_rise) parity_err <= 1'b0;
         if (w_udr_rise && !w_par_ok) parity_err <= 1'b1;
      end
   end
`else
   assign w_par_ok = 1'b1;
`endif

   assign w_push         = w_udr_rise && w_par_ok;
   assign w_pop          = cmd_valid && cmd_ready;
   assign w_push_data.ir   = ir_in;
   assign w_push_data.data = sr;

   dbg_cmd_fifo #(
      .DEPTH (DEPTH),
      .T     (cmd_t)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (w_push),
      .push_data (w_push_data),
      .pop       (w_pop),
      .head      (w_head),
      .full      (w_full),
      .empty     (w_empty),
      .level     (fifo_level)
   );

   assign cmd_valid = !w_empty;
   assign cmd_ir    = w_head.ir;
   assign w_onehot  = N_CMD'(action_onehot(32'(w_head.ir)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         jdo            <= '0;
         take_action    <= '0;
         take_no_action <= '0;
         overflow       <= 1'b0;
      end else begin
         take_action    <= '0;
         take_no_action <= '0;
         if (w_pop) begin
            jdo <= w_head.data;
            if (w_head.data[ACTION_BIT]) take_action    <= w_onehot;
            else                         take_no_action <= w_onehot;
         end
         if (w_uir_rise) overflow <= 1'b0;
         if (w_push && w_full && !w_pop) overflow <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dbg_cmd_sysclk_decoder.sv
`default_nettype none
// ============================================================================
// tb_dbg_cmd_sysclk_decoder : random udr/uir traffic against a queue-based model
// Revision                  : 1.0
// ============================================================================
module tb_dbg_cmd_sysclk_decoder;

   localparam int DW    = 38;
   localparam int SYNC  = 2;
   localparam int DEPTH = 4;

   typedef struct {
      logic [1:0]    ir;
      logic [DW-1:0] data;
   } mcmd_t;

   typedef struct {
      int    at;
      mcmd_t c;
      bit    par_ok;
   } pend_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [1:0]    ir_in = '0;
   logic [DW-1:0] sr = '0;
   logic          sr_par = 1'b0;
   logic          vs_udr = 1'b0;
   logic          vs_uir = 1'b0;
   logic          cmd_ready = 1'b0;
   logic          cmd_valid;
   logic [1:0]    cmd_ir;
   logic [DW-1:0] jdo;
   logic [3:0]    take_action;
   logic [3:0]    take_no_action;
   logic          overflow;
   logic          parity_err;
   logic [2:0]    fifo_level;

   int            n_total = 0;
   int            n_bad = 0;
   int            cyc = 0;
   bit            rnd_ready = 0;

   mcmd_t         q[$];
   pend_t         pend[$];
   int            uir_at[$];
   bit            m_ovf = 0;
   bit            m_perr = 0;
   logic [DW-1:0] exp_jdo = '0;
   logic [3:0]    exp_ta = '0;
   logic [3:0]    exp_tna = '0;

   always #5 clk = ~clk;

   dbg_cmd_sysclk_decoder dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .ir_in          (ir_in),
      .sr             (sr),
      .vs_udr         (vs_udr),
      .vs_uir         (vs_uir),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_ir         (cmd_ir),
      .jdo            (jdo),
      .take_action    (take_action),
      .take_no_action (take_no_action),
      .overflow       (overflow),
`ifdef DBG_CMD_PARITY_EN
      .sr_par         (sr_par),
      .parity_err     (parity_err),
`endif
      .fifo_level     (fifo_level)
   );

`ifndef DBG_CMD_PARITY_EN
   assign parity_err = 1'b0;
`endif

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Advance one clock: apply the spec rules at the edge, then compare at the falling edge.
   task automatic tick();
      pend_t e;
      mcmd_t p;
      @(posedge clk);
      cyc++;
      exp_ta  = '0;
      exp_tna = '0;
      if (q.size() != 0 && cmd_ready) begin
         p = q.pop_front();
         exp_jdo = p.data;
         if (p.data[DW-1]) exp_ta  = 4'(1) << p.ir;
         else              exp_tna = 4'(1) << p.ir;
      end
      if (uir_at.size() != 0 && uir_at[0] == cyc) begin
         void'(uir_at.pop_front());
         m_ovf  = 0;
         m_perr = 0;
      end
      if (pend.size() != 0 && pend[0].at == cyc) begin
         e = pend.pop_front();
         if (!e.par_ok)            m_perr = 1;
         else if (q.size() < DEPTH) q.push_back(e.c);
         else                      m_ovf = 1;
      end
      @(negedge clk);
      check("cmd_valid", cmd_valid, q.size() != 0);
      check("fifo_level", fifo_level, q.size());
      if (q.size() != 0) check("cmd_ir", cmd_ir, q[0].ir);
      check("jdo", jdo, exp_jdo);
      check("take_action", take_action, exp_ta);
      check("take_no_action", take_no_action, exp_tna);
      check("overflow", overflow, m_ovf);
`ifdef DBG_CMD_PARITY_EN
      check("parity_err", parity_err, m_perr);
`endif
      if (rnd_ready) cmd_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic udr_pulse(input logic [1:0] ir, input logic [DW-1:0] d, input logic par);
      pend_t e;
      ir_in  = ir;
      sr     = d;
      sr_par = par;
      vs_udr = 1'b1;
      e.at     = cyc + 1 + SYNC;
      e.c.ir   = ir;
      e.c.data = d;
`ifdef DBG_CMD_PARITY_EN
      e.par_ok = ((^d) == par);
`else
      e.par_ok = 1;
`endif
      pend.push_back(e);
      repeat (3) tick();
      vs_udr = 1'b0;
      repeat (3) tick();
   endtask

   task automatic uir_pulse();
      vs_uir = 1'b1;
      uir_at.push_back(cyc + 1 + SYNC);
      repeat (3) tick();
      vs_uir = 1'b0;
      repeat (3) tick();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      q.delete();
      pend.delete();
      uir_at.delete();
      m_ovf   = 0;
      m_perr  = 0;
      exp_jdo = '0;
      exp_ta  = '0;
      exp_tna = '0;
      #1;
      check("rst_cmd_valid", cmd_valid, 1'b0);
      check("rst_fifo_level", fifo_level, 3'd0);
      check("rst_jdo", jdo, '0);
      check("rst_take_action", take_action, 4'd0);
      check("rst_take_no_action", take_no_action, 4'd0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_parity_err", parity_err, 1'b0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      logic [63:0]   rv;
      logic [DW-1:0] d;
      logic          par;

      // Strobe already high across reset release must not create a command.
      vs_udr = 1'b1;
      @(negedge clk);
      do_reset();
      repeat (8) tick();
      vs_udr = 1'b0;
      repeat (4) tick();

      cmd_ready = 1'b1;
      udr_pulse(2'd2, 38'h20_0000_00AB, 1'b1);
      udr_pulse(2'd1, 38'h0_1234_5678, 1'b1);

      // Overflow: five updates into a four-entry FIFO, then drain and clear.
      cmd_ready = 1'b0;
      for (int i = 0; i < 5; i++) udr_pulse(2'(i), {1'b1, 37'(i * 17 + 3)}, 1'b0);
      cmd_ready = 1'b1;
      repeat (6) tick();
      uir_pulse();

      // Full FIFO with a pop landing on the same edge as the push.
      cmd_ready = 1'b0;
      for (int i = 0; i < 4; i++) udr_pulse(2'(3 - i), 38'(i + 100), 1'b0);
      ir_in  = 2'd3;
      sr     = 38'h2A_BCDE_F012;
      vs_udr = 1'b1;
      pend.push_back('{at: cyc + 1 + SYNC, c: '{ir: 2'd3, data: 38'h2A_BCDE_F012}, par_ok: 1});
      repeat (2) tick();
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      tick();
      vs_udr = 1'b0;
      repeat (3) tick();
      cmd_ready = 1'b1;
      repeat (6) tick();

`ifdef DBG_CMD_PARITY_EN
      udr_pulse(2'd0, 38'h1, 1'b0);
      udr_pulse(2'd0, 38'h1, 1'b1);
      repeat (2) tick();
      uir_pulse();
`endif

      // Randomised traffic with random back-pressure.
      rnd_ready = 1;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            uir_pulse();
         end else begin
            rv  = {$urandom(), $urandom()};
            d   = rv[DW-1:0];
            par = (^d) ^ ($urandom_range(0, 7) == 0);
            udr_pulse(2'($urandom_range(0, 3)), d, par);
         end
         repeat ($urandom_range(0, 3)) tick();
      end
      rnd_ready = 0;
      cmd_ready = 1'b1;
      repeat (6) tick();

      // Reset with three entries queued clears them immediately.
      cmd_ready = 1'b0;
      for (int i = 0; i < 3; i++) udr_pulse(2'(i), 38'(i + 7), 1'b0);
      do_reset();
      cmd_ready = 1'b1;
      repeat (6) tick();
      udr_pulse(2'd3, 38'h3F_0000_0001, 1'b0);
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dbg_cmd_sysclk_decoder.md
# dbg_cmd_sysclk_decoder

Parametrised system-clock half of the processor JTAG debug slave. It samples the update strobes of the virtual-JTAG (TCK) domain through internal synchronisers, captures the shifted data register together with the instruction register, and buffers each update in a small command FIFO. Commands are presented on a valid/ready port and decoded into one-cycle take_action/take_no_action pulses per IR code. It replaces the fixed 2-bit-IR, 38-bit, unbuffered sysclk decoder and sits between the debug TCK block and the OCI memory, break and trace-control logic.

## Interface
- DATA_W, 38: width of the shifted data register and of jdo.
- IR_W, 2: instruction register width; N_CMD = 2**IR_W decoded channels.
- ACTION_BIT, DATA_W-1: bit of sr that selects take_action (1) or take_no_action (0).
- DEPTH, 4: command FIFO depth, a power of two ≥2.
- SYNC_STAGES, 2: synchroniser flops per TCK-domain strobe, ≥2.

- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ir_in  in  IR_W  TCK-domain IR; stable while vs_udr is high.
- sr  in  DATA_W  TCK-domain shift register; stable while vs_udr is high.
- vs_udr  in  1  TCK-domain update-DR level, asynchronous to clk.
- vs_uir  in  1  TCK-domain update-IR level, asynchronous to clk.
- cmd_valid  out  1  FIFO head holds a command.
- cmd_ready  in  1  consumer accepts the head this cycle.
- cmd_ir  out  IR_W  IR of the head entry.
- jdo  out  DATA_W  data of the last popped command; holds until the next pop.
- take_action  out  N_CMD  one-hot, one-cycle pulse.
- take_no_action  out  N_CMD  one-hot, one-cycle pulse.
- overflow  out  1  sticky: an update was dropped because the FIFO was full.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Each of vs_udr and vs_uir passes through SYNC_STAGES flops, followed by one edge register. A rise equals synchronised value 1 while the edge register holds 0.
- Arming counter: after reset release, rise detection stays disabled for SYNC_STAGES+1 cycles. An strobe already high at reset release therefore produces no command.
- udr rise: push {ir_in, sr} into the FIFO. ir_in and sr are sampled directly; the system guarantees they are stable for at least SYNC_STAGES+3 clk cycles after vs_udr rises.
- Push while full, with no pop in the same cycle: the entry is dropped and overflow is set. Push while full with a simultaneous pop: the push is accepted and level is unchanged.
- uir rise: clears overflow (and parity_err, see Configuration). FIFO contents are untouched.
- Handshake: a pop occurs when cmd_valid && cmd_ready. On the next edge, jdo takes the head data. In the same cycle, exactly one bit is pulsed: take_action[cmd_ir] if data[ACTION_BIT] is 1, otherwise take_no_action[cmd_ir]. cmd_ready while cmd_valid is low has no effect.
- FIFO read and write pointers are IR_W-independent and wrap modulo DEPTH. Level is computed as wptr−rptr, with one extra pointer bit to distinguish full from empty.

## Timing
- Reset values: cmd_valid=0, jdo=0, take_action=0, take_no_action=0, overflow=0, fifo_level=0. Synchroniser and edge flops reset to 0; FIFO is empty.
- Latency: vs_udr first sampled high at edge 0 → push at edge SYNC_STAGES → cmd_valid high after edge SYNC_STAGES.
- Pop at edge P: jdo valid and pulse high after edge P, for exactly one cycle. The next head is visible on cmd_ir and cmd_valid after edge P.
- Back-to-back pops are allowed every cycle; throughput is 1 command per clk.
- Reset asserted mid-operation clears all state immediately, including queued commands and the arming counter. No pulse is emitted during or after reset without a fresh udr rise.

## Configuration
- DBG_CMD_PARITY_EN: adds input sr_par (1 bit, even parity over sr, same stability rule as sr) and output parity_err (sticky, reset 0, cleared by uir rise).
  - On a udr rise with mismatching parity, the command is not pushed and parity_err is set.
  - A parity drop does not set overflow.
  - Without the macro, neither port exists and every udr rise is pushed per the rules above.

## Structure
- Package dbg_cmd_pkg holds:
  - default localparams (DATA_W, IR_W, DEPTH, SYNC_STAGES);
  - typedef dbg_cmd_t as a packed struct {ir, data};
  - function action_onehot(ir).
- Sub-module dbg_cmd_fifo: DEPTH-entry show-ahead FIFO of dbg_cmd_t, with push/pop/full/empty/level.
- The synchronisers, arming counter, decode and the jdo register stay in the top module.

## Test plan
All scenarios use the defaults: DATA_W=38, IR_W=2, DEPTH=4, SYNC_STAGES=2.
- Basic action: ir_in=2, sr=38'h20_0000_00AB, vs_udr pulse, cmd_ready=1 → cmd_valid after edge 2; on the next edge jdo=38'h20_0000_00AB and take_action=4'b0100 for one cycle.
- No-action: ir_in=1, sr bit37=0, sr=38'h0_1234_5678 → take_no_action=4'b0010; take_action stays 0.
- Overflow: cmd_ready=0, five udr pulses → fifo_level=4 and overflow=1. Then drain → four pops in order with the fifth missing. A uir pulse then clears overflow.
- Full with simultaneous push and pop: FIFO full and cmd_ready=1 when a udr rise arrives → entry accepted, level stays 4, overflow stays 0.
- Reset: vs_udr held high through reset release → no command. Reset asserted with 3 entries queued → cmd_valid=0 and fifo_level=0 immediately.
- Parity (DBG_CMD_PARITY_EN defined): sr=38'h1, sr_par=0 → no push, parity_err=1. sr_par=1 → command pushed.
